// File: rtl/sprite_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sprite_table_ctrl
// Purpose  : Sprite slot table owner. Requesters update a shadow table through
//            a round-robin arbiter. The shadow table is copied to the active
//            table that feeds the sprite mapper once per frame, on the VSync
//            falling edge, so the mapper never sees a half-updated frame.
//            clear_all empties the shadow table with a 16-cycle sweep.
// Ports    : Clk, Reset_n (async, active low)
//            VSync          - active-low vertical sync
//            clear_all      - one-cycle pulse, empties every shadow slot
//            req_valid/ready- per-requester handshake (ready is one-hot)
//            req_op/slot/posx/posy/id - per-requester packed request fields
//            pos_x_flat/pos_y_flat/sprite_id_flat - active table, slot k at
//                             [10k+9:10k] / [4k+3:4k]
//            frame_commit   - pulses for the cycle after the active load edge
//            busy           - high while sweeping
// Options  : `define SPRITE_OFFSCREEN_CULL_EN to load off-screen slots
//            (x >= 640 or y >= 480) into the active table as empty.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_table_ctrl #(
  parameter int         NUM_SLOTS = 16,
  parameter int         NUM_REQ   = 3,
  parameter logic [3:0] ID_EMPTY  = 4'hF
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    VSync,
  input  logic                    clear_all,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [4*NUM_REQ-1:0]    req_slot,
  input  logic [10*NUM_REQ-1:0]   req_posx,
  input  logic [10*NUM_REQ-1:0]   req_posy,
  input  logic [4*NUM_REQ-1:0]    req_id,
  output logic [10*NUM_SLOTS-1:0] pos_x_flat,
  output logic [10*NUM_SLOTS-1:0] pos_y_flat,
  output logic [4*NUM_SLOTS-1:0]  sprite_id_flat,
  output logic                    frame_commit,
  output logic                    busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] OP_POS   = 2'b00;
  localparam logic [1:0] OP_ID    = 2'b01;
  localparam logic [1:0] OP_BOTH  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         sweep_cnt_q, sweep_cnt_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               commit_pending_q, commit_pending_d;
  logic               vsync_q;
  logic               frame_commit_q;

  logic [9:0] shadow_x_q  [NUM_SLOTS];
  logic [9:0] shadow_y_q  [NUM_SLOTS];
  logic [3:0] shadow_id_q [NUM_SLOTS];
  logic [9:0] shadow_x_d  [NUM_SLOTS];
  logic [9:0] shadow_y_d  [NUM_SLOTS];
  logic [3:0] shadow_id_d [NUM_SLOTS];
  logic [9:0] active_x_q  [NUM_SLOTS];
  logic [9:0] active_y_q  [NUM_SLOTS];
  logic [3:0] active_id_q [NUM_SLOTS];
  logic [3:0] active_id_d [NUM_SLOTS];

  logic             in_run;
  logic             vsync_fall;
  logic             commit;
  logic             arb_found;
  logic             grant_any;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand;
  logic [1:0]       gnt_op;
  logic [3:0]       gnt_slot;
  logic [9:0]       gnt_x;
  logic [9:0]       gnt_y;
  logic [3:0]       gnt_id;
  logic             gnt_slot_ok;

  assign in_run     = (state_q == ST_RUN);
  assign vsync_fall = vsync_q & ~VSync;
  // A commit deferred by a sweep is taken in the first RUN cycle afterwards.
  assign commit     = in_run & (vsync_fall | commit_pending_q);

  // --------------------------------------------------------------------------
  // Round-robin arbiter: search starts just after the last granted index.
  // --------------------------------------------------------------------------
  always_comb begin
    arb_found = 1'b0;
    grant_idx = rr_ptr_q;
    cand      = '0;
    req_ready = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        grant_idx = cand;
      end
    end
    // A clear_all pulse takes priority over any grant in the same cycle.
    grant_any = arb_found & in_run & ~clear_all;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign gnt_op      = req_op  [2*grant_idx  +: 2];
  assign gnt_slot    = req_slot[4*grant_idx  +: 4];
  assign gnt_x       = req_posx[10*grant_idx +: 10];
  assign gnt_y       = req_posy[10*grant_idx +: 10];
  assign gnt_id      = req_id  [4*grant_idx  +: 4];
  // Out-of-range slots are still handshaken, but the write is dropped.
  assign gnt_slot_ok = ({1'b0, gnt_slot} < 5'(NUM_SLOTS));

  // --------------------------------------------------------------------------
  // Shadow table next state: granted write in RUN, one-slot clear in SWEEP.
  // --------------------------------------------------------------------------
  always_comb begin
    shadow_x_d  = shadow_x_q;
    shadow_y_d  = shadow_y_q;
    shadow_id_d = shadow_id_q;
    if (grant_any && gnt_slot_ok) begin
      case (gnt_op)
        OP_POS: begin
          shadow_x_d[gnt_slot] = gnt_x;
          shadow_y_d[gnt_slot] = gnt_y;
        end
        OP_ID: begin
          shadow_id_d[gnt_slot] = gnt_id;
        end
        OP_BOTH: begin
          shadow_x_d[gnt_slot]  = gnt_x;
          shadow_y_d[gnt_slot]  = gnt_y;
          shadow_id_d[gnt_slot] = gnt_id;
        end
        OP_CLEAR: begin
          shadow_id_d[gnt_slot] = ID_EMPTY;
        end
        default: ;
      endcase
    end
    if (!in_run && ({1'b0, sweep_cnt_q} < 5'(NUM_SLOTS))) begin
      shadow_id_d[sweep_cnt_q] = ID_EMPTY;
    end
  end

  // --------------------------------------------------------------------------
  // Active IDs loaded at commit; the shadow ID itself is never modified here.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NUM_SLOTS; k++) begin
      active_id_d[k] = shadow_id_q[k];
`ifdef SPRITE_OFFSCREEN_CULL_EN
      if ((shadow_x_q[k] >= 10'd640) || (shadow_y_q[k] >= 10'd480)) begin
        active_id_d[k] = ID_EMPTY;
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    sweep_cnt_d      = sweep_cnt_q;
    commit_pending_d = commit_pending_q;
    rr_ptr_d         = grant_any ? grant_idx : rr_ptr_q;
    case (state_q)
      ST_RUN: begin
        if (commit) begin
          commit_pending_d = 1'b0;
        end
        if (clear_all) begin
          state_d     = ST_SWEEP;
          sweep_cnt_d = 4'd0;
        end
      end
      ST_SWEEP: begin
        // Any number of VSync edges during the sweep collapse into one commit.
        if (vsync_fall) begin
          commit_pending_d = 1'b1;
        end
        sweep_cnt_d = sweep_cnt_q + 4'd1;
        if (sweep_cnt_q == 4'd15) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q          <= ST_RUN;
      sweep_cnt_q      <= 4'd0;
      rr_ptr_q         <= '0;
      commit_pending_q <= 1'b0;
      vsync_q          <= 1'b1;
      frame_commit_q   <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        shadow_x_q[k]  <= '0;
        shadow_y_q[k]  <= '0;
        shadow_id_q[k] <= ID_EMPTY;
        active_x_q[k]  <= '0;
        active_y_q[k]  <= '0;
        active_id_q[k] <= ID_EMPTY;
      end
    end else begin
      state_q          <= state_d;
      sweep_cnt_q      <= sweep_cnt_d;
      rr_ptr_q         <= rr_ptr_d;
      commit_pending_q <= commit_pending_d;
      vsync_q          <= VSync;
      frame_commit_q   <= commit;
      shadow_x_q       <= shadow_x_d;
      shadow_y_q       <= shadow_y_d;
      shadow_id_q      <= shadow_id_d;
      // Loads the pre-write shadow contents; a same-cycle write waits a frame.
      if (commit) begin
        active_x_q  <= shadow_x_q;
        active_y_q  <= shadow_y_q;
        active_id_q <= active_id_d;
      end
    end
  end

  generate
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_flat
      assign pos_x_flat[10*k +: 10]    = active_x_q[k];
      assign pos_y_flat[10*k +: 10]    = active_y_q[k];
      assign sprite_id_flat[4*k +: 4]  = active_id_q[k];
    end
  endgenerate

  assign frame_commit = frame_commit_q;
  assign busy         = (state_q == ST_SWEEP);

endmodule
`default_nettype wire

// File: tb/tb_sprite_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_table_ctrl
// Purpose  : Self-checking bench for sprite_table_ctrl. A frame-level model
//            (shadow/active arrays, sweep countdown, pending-commit flag)
//            predicts handshakes, busy, frame_commit and the active table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_table_ctrl;

`ifdef SPRITE_OFFSCREEN_CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         VSync;
  logic         clear_all;
  logic [2:0]   req_valid;
  logic [2:0]   req_ready;
  logic [5:0]   req_op;
  logic [11:0]  req_slot;
  logic [29:0]  req_posx;
  logic [29:0]  req_posy;
  logic [11:0]  req_id;
  logic [159:0] pos_x_flat;
  logic [159:0] pos_y_flat;
  logic [63:0]  sprite_id_flat;
  logic         frame_commit;
  logic         busy;

  sprite_table_ctrl dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .VSync         (VSync),
    .clear_all     (clear_all),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_slot      (req_slot),
    .req_posx      (req_posx),
    .req_posy      (req_posy),
    .req_id        (req_id),
    .pos_x_flat    (pos_x_flat),
    .pos_y_flat    (pos_y_flat),
    .sprite_id_flat(sprite_id_flat),
    .frame_commit  (frame_commit),
    .busy          (busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_sx[16], m_sy[16], m_sid[16];
  int m_ax[16], m_ay[16], m_aid[16];
  int m_last, m_sweep_left, m_sweep_slot;
  bit m_pend, m_vsprev, m_fc;
  logic [2:0] obs_ready;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_sx[k] = 0; m_sy[k] = 0; m_sid[k] = 15;
      m_ax[k] = 0; m_ay[k] = 0; m_aid[k] = 15;
    end
    m_last = 0; m_sweep_left = 0; m_sweep_slot = 0;
    m_pend = 1'b0; m_vsprev = 1'b1; m_fc = 1'b0;
  endtask

  task automatic check_outputs();
    chk("busy", 0, {31'd0, busy}, (m_sweep_left > 0) ? 32'd1 : 32'd0);
    chk("frame_commit", 0, {31'd0, frame_commit}, {31'd0, m_fc});
    for (int k = 0; k < 16; k++) begin
      chk("act_x", k, {22'd0, pos_x_flat[10*k +: 10]}, m_ax[k]);
      chk("act_y", k, {22'd0, pos_y_flat[10*k +: 10]}, m_ay[k]);
      chk("act_id", k, {28'd0, sprite_id_flat[4*k +: 4]}, m_aid[k]);
    end
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic cycle();
    int  g, c, op, slot;
    bit  in_run, fall, commit;
    #1;
    in_run = (m_sweep_left == 0);
    fall   = m_vsprev && !VSync;
    g = -1;
    if (in_run && !clear_all) begin
      for (int d = 1; d <= 3; d++) begin
        c = (m_last + d) % 3;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    obs_ready = req_ready;
    chk("req_ready", 0, {29'd0, req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
    commit = in_run && (fall || m_pend);
    if (commit) begin
      for (int k = 0; k < 16; k++) begin
        m_ax[k]  = m_sx[k];
        m_ay[k]  = m_sy[k];
        m_aid[k] = (CULL && (m_sx[k] >= 640 || m_sy[k] >= 480)) ? 15 : m_sid[k];
      end
    end
    m_pend = in_run ? 1'b0 : (m_pend || fall);
    m_fc   = commit;
    if (g >= 0) begin
      op   = int'(req_op[2*g +: 2]);
      slot = int'(req_slot[4*g +: 4]);
      if (op == 0 || op == 2) begin
        m_sx[slot] = int'(req_posx[10*g +: 10]);
        m_sy[slot] = int'(req_posy[10*g +: 10]);
      end
      if (op == 1 || op == 2) m_sid[slot] = int'(req_id[4*g +: 4]);
      if (op == 3) m_sid[slot] = 15;
      m_last = g;
    end
    if (in_run) begin
      if (clear_all) begin
        m_sweep_left = 16;
        m_sweep_slot = 0;
      end
    end else begin
      m_sid[m_sweep_slot] = 15;
      m_sweep_slot++;
      m_sweep_left--;
    end
    m_vsprev = VSync;
    @(posedge Clk);
    #1;
    check_outputs();
    @(negedge Clk);
  endtask

  task automatic set_req(input int r, input int op, input int slot, input int x, input int y, input int id);
    req_op[2*r +: 2]    = 2'(op);
    req_slot[4*r +: 4]  = 4'(slot);
    req_posx[10*r +: 10] = 10'(x);
    req_posy[10*r +: 10] = 10'(y);
    req_id[4*r +: 4]    = 4'(id);
  endtask

  task automatic vsync_pulse();
    VSync = 1'b0; cycle();
    VSync = 1'b1; cycle();
  endtask

  int busy_cnt;
  int order[6];

  initial begin
    Reset_n = 1'b0; VSync = 1'b1; clear_all = 1'b0; req_valid = '0;
    req_op = '0; req_slot = '0; req_posx = '0; req_posy = '0; req_id = '0;
    model_reset();
    repeat (3) @(negedge Clk);
    #1;
    check_outputs();
    chk("reset_ids_lo", 0, sprite_id_flat[31:0], 32'hFFFF_FFFF);
    chk("reset_ids_hi", 0, sprite_id_flat[63:32], 32'hFFFF_FFFF);
    @(negedge Clk);
    Reset_n = 1'b1;

    // First frame commit out of reset
    VSync = 1'b0; cycle();
    chk("first_commit", 0, {31'd0, frame_commit}, 32'd1);
    chk("first_ids", 0, sprite_id_flat[31:0], 32'hFFFF_FFFF);
    VSync = 1'b1; cycle();

    // Round-robin fairness with everyone requesting
    order = '{1, 2, 0, 1, 2, 0};
    req_valid = 3'b111;
    for (int r = 0; r < 3; r++) set_req(r, 2, 8 + r, 10 * r, 20 * r, r + 4);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("grant_order", i, {29'd0, obs_ready}, 32'd1 << order[i]);
    end
    req_valid = '0;

    // Write slot 3, not visible until the next VSync falling edge
    set_req(0, 2, 3, 100, 200, 2);
    req_valid = 3'b001; cycle(); req_valid = '0;
    cycle();
    chk("slot3_before", 0, {28'd0, sprite_id_flat[15:12]}, 32'hF);
    vsync_pulse();
    chk("slot3_x", 0, {22'd0, pos_x_flat[39:30]}, 32'd100);
    chk("slot3_y", 0, {22'd0, pos_y_flat[39:30]}, 32'd200);

    // Sweep with req1 waiting and a VSync edge in sweep cycle 5
    set_req(1, 1, 2, 0, 0, 9);
    req_valid = 3'b010; clear_all = 1'b1;
    busy_cnt = 0;
    cycle();
    clear_all = 1'b0;
    if (busy) busy_cnt++;
    for (int i = 0; i < 16; i++) begin
      VSync = (i == 5) ? 1'b0 : 1'b1;
      if (i == 8) clear_all = 1'b1;
      else clear_all = 1'b0;
      cycle();
      if (busy) busy_cnt++;
    end
    VSync = 1'b1; clear_all = 1'b0;
    chk("busy_len", 0, busy_cnt, 32'd16);
    cycle();
    chk("post_sweep_commit", 0, {31'd0, frame_commit}, 32'd1);
    chk("post_sweep_ids_lo", 0, sprite_id_flat[31:0], 32'hFFFF_FFFF);
    chk("post_sweep_ids_hi", 0, sprite_id_flat[63:32], 32'hFFFF_FFFF);
    req_valid = '0;
    cycle();

    // Write granted in the commit cycle lands one frame later
    set_req(0, 1, 7, 0, 0, 5);
    req_valid = 3'b001; VSync = 1'b0; cycle();
    req_valid = '0;
    chk("slot7_same_frame", 0, {28'd0, sprite_id_flat[31:28]}, 32'hF);
    VSync = 1'b1; cycle();
    vsync_pulse();
    chk("slot7_next_frame", 0, {28'd0, sprite_id_flat[31:28]}, 32'd5);

    // Off-screen slot handling at commit
    set_req(0, 2, 0, 650, 10, 1);
    req_valid = 3'b001; cycle(); req_valid = '0;
    vsync_pulse();
    chk("cull_offscreen", 0, {28'd0, sprite_id_flat[3:0]}, CULL ? 32'hF : 32'd1);
    set_req(0, 0, 0, 600, 10, 0);
    req_valid = 3'b001; cycle(); req_valid = '0;
    vsync_pulse();
    chk("cull_onscreen", 0, {28'd0, sprite_id_flat[3:0]}, 32'd1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 3'($urandom_range(0, 7));
      for (int r = 0; r < 3; r++)
        set_req(r, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 15));
      VSync     = ($urandom_range(0, 9) != 0);
      clear_all = ($urandom_range(0, 79) == 0);
      cycle();
    end
    clear_all = 1'b0; VSync = 1'b1; req_valid = '0;
    cycle();

    // Asynchronous reset in the middle of a sweep with a commit pending
    clear_all = 1'b1; cycle(); clear_all = 1'b0;
    VSync = 1'b0; cycle(); VSync = 1'b1; cycle();
    Reset_n = 1'b0;
    #1;
    model_reset();
    chk("mid_reset_busy", 0, {31'd0, busy}, 32'd0);
    chk("mid_reset_ids", 0, sprite_id_flat[31:0], 32'hFFFF_FFFF);
    check_outputs();
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    vsync_pulse();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
